// File: rtl/risc_pipe_ctrl_pkg.sv
// Shared constants for the RISC pipeline control block: forwarding selects and stage indices.
package risc_pipe_ctrl_pkg;

  localparam logic [1:0] FWD_REG = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  localparam int unsigned STG_IF  = 0;
  localparam int unsigned STG_DOF = 1;
  localparam int unsigned STG_EX  = 2;

endpackage

// File: rtl/risc_pipe_ctrl_fwd.sv
// Operand forwarding compare for one DOF source: EX result wins over WB, r0 never forwards.
module risc_pipe_ctrl_fwd
  import risc_pipe_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] src,
  input  logic              src_used,
  input  logic [ADDR_W-1:0] ex_dr,
  input  logic              ex_rw,
  input  logic              ex_valid,
  input  logic [ADDR_W-1:0] wb_dr,
  input  logic              wb_rw,
  input  logic              wb_valid,
  output logic              ex_match,
  output logic [1:0]        sel
);

  logic src_live;
  logic wb_match;

  assign src_live = src_used & (|src);
  assign ex_match = src_live & ex_rw & ex_valid & (ex_dr == src);
  assign wb_match = src_live & wb_rw & wb_valid & (wb_dr == src);

  always_comb begin
    sel = FWD_REG;
    if (ex_match) begin
      sel = FWD_EX;
    end else if (wb_match) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/risc_pipe_ctrl.sv
// Pipeline control for the IF/DOF/EX/WB datapath: valid/halt tracking, forwarding, load-use
// stall, branch flush with shadow, reset warm-up, sticky halt and performance counters.
module risc_pipe_ctrl
  import risc_pipe_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned STAGES  = 4,
  parameter int unsigned WARMUP  = 2,
  parameter int unsigned MEM_LAT = 0,
  parameter int unsigned SHADOW  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] id_sa,
  input  logic [ADDR_W-1:0] id_sb,
  input  logic              id_use_a,
  input  logic              id_use_b,
  input  logic [ADDR_W-1:0] ex_dr,
  input  logic              ex_rw,
  input  logic              ex_is_load,
  input  logic [ADDR_W-1:0] wb_dr,
  input  logic              wb_rw,
  input  logic              ex_br_taken,
  input  logic              if_halt,
  output logic              pc_load,
  output logic [STAGES-1:0] stage_valid,
  output logic              flush_if,
  output logic              flush_id,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              halt,
  output logic [31:0]       retire_cnt,
  output logic [15:0]       stall_cnt
);

  localparam int unsigned WarmW = $clog2(WARMUP + 1);

  logic [WarmW-1:0]  warm_q;
  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] hmark_q, hmark_d;
  logic [1:0]        shadow_q;
  logic              halt_q;
  logic [31:0]       retire_q;
  logic [15:0]       stall_q;

  logic warm_done;
  logic fetch_ok;
  logic a_ex_match;
  logic b_ex_match;
  logic stall;
  logic retire;

  risc_pipe_ctrl_fwd #(
    .ADDR_W(ADDR_W)
  ) u_fwd_a (
    .src     (id_sa),
    .src_used(id_use_a),
    .ex_dr   (ex_dr),
    .ex_rw   (ex_rw),
    .ex_valid(valid_q[STG_EX]),
    .wb_dr   (wb_dr),
    .wb_rw   (wb_rw),
    .wb_valid(valid_q[STAGES-1]),
    .ex_match(a_ex_match),
    .sel     (fwd_a_sel)
  );

  risc_pipe_ctrl_fwd #(
    .ADDR_W(ADDR_W)
  ) u_fwd_b (
    .src     (id_sb),
    .src_used(id_use_b),
    .ex_dr   (ex_dr),
    .ex_rw   (ex_rw),
    .ex_valid(valid_q[STG_EX]),
    .wb_dr   (wb_dr),
    .wb_rw   (wb_rw),
    .wb_valid(valid_q[STAGES-1]),
    .ex_match(b_ex_match),
    .sel     (fwd_b_sel)
  );

  assign warm_done = (warm_q == WarmW'(WARMUP));
  assign fetch_ok  = warm_done & ~halt_q;

  // A taken branch discards the dependent instruction, so the flush overrides the stall.
  assign stall = (MEM_LAT != 0) & ex_is_load & (a_ex_match | b_ex_match) & ~ex_br_taken & ~halt_q;

  assign pc_load  = fetch_ok & ~stall;
  assign flush_if = ex_br_taken | (shadow_q != 2'd0);
  assign flush_id = ex_br_taken;
  assign retire   = valid_q[STAGES-1] & ~hmark_q[STAGES-1] & ~halt_q;

  always_comb begin
    valid_d = valid_q;
    hmark_d = hmark_q;
    if (!halt_q) begin
      for (int k = STG_EX + 1; k < STAGES; k++) begin
        valid_d[k] = valid_q[k-1];
        hmark_d[k] = hmark_q[k-1];
      end
      // EX receives a bubble while IF/DOF hold during a stall.
      valid_d[STG_EX] = valid_q[STG_DOF] & ~flush_id & ~stall;
      hmark_d[STG_EX] = hmark_q[STG_DOF] & ~flush_id & ~stall;
      if (!stall) begin
        valid_d[STG_DOF] = valid_q[STG_IF] & ~flush_id;
        hmark_d[STG_DOF] = hmark_q[STG_IF] & ~flush_id;
        valid_d[STG_IF]  = fetch_ok & ~flush_if;
        hmark_d[STG_IF]  = fetch_ok & ~flush_if & if_halt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      warm_q   <= '0;
      valid_q  <= '0;
      hmark_q  <= '0;
      shadow_q <= 2'd0;
      halt_q   <= 1'b0;
      retire_q <= '0;
      stall_q  <= '0;
    end else begin
      if (!warm_done) begin
        warm_q <= warm_q + WarmW'(1);
      end
      valid_q <= valid_d;
      hmark_q <= hmark_d;
      halt_q  <= halt_q | (&hmark_d);
      if (ex_br_taken) begin
        shadow_q <= 2'(SHADOW);
      end else if (shadow_q != 2'd0) begin
        shadow_q <= shadow_q - 2'd1;
      end
      if (retire && (retire_q != '1)) begin
        retire_q <= retire_q + 32'd1;
      end
      if (stall && (stall_q != '1)) begin
        stall_q <= stall_q + 16'd1;
      end
    end
  end

  assign stage_valid = valid_q;
  assign halt        = halt_q;
  assign retire_cnt  = retire_q;
  assign stall_cnt   = stall_q;

endmodule

// File: tb/tb_risc_pipe_ctrl.sv
// Scoreboard bench for risc_pipe_ctrl with MEM_LAT=1, WARMUP=2, SHADOW=1, four stages.
module tb_risc_pipe_ctrl;

  typedef struct packed {
    logic       pc_load;
    logic [3:0] valid;
    logic       fl_if;
    logic       fl_id;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       halt;
  } snap_t;

  typedef struct packed {
    logic [4:0] sa;
    logic [4:0] sb;
    logic       ua;
    logic       ub;
    logic [4:0] exd;
    logic       exrw;
    logic [4:0] wbd;
    logic       wbrw;
    logic [1:0] fa;
    logic [1:0] fb;
  } fwd_vec_t;

  logic        clk;
  logic        rst_n;
  logic [4:0]  id_sa, id_sb, ex_dr, wb_dr;
  logic        id_use_a, id_use_b, ex_rw, ex_is_load, wb_rw, ex_br_taken, if_halt;
  logic        pc_load, flush_if, flush_id, halt;
  logic [3:0]  stage_valid;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic [31:0] retire_cnt;
  logic [15:0] stall_cnt;

  snap_t act;
  snap_t e;
  snap_t exp_q[$];
  int    total;
  int    bad;

  risc_pipe_ctrl #(
    .ADDR_W (5),
    .STAGES (4),
    .WARMUP (2),
    .MEM_LAT(1),
    .SHADOW (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .id_sa      (id_sa),
    .id_sb      (id_sb),
    .id_use_a   (id_use_a),
    .id_use_b   (id_use_b),
    .ex_dr      (ex_dr),
    .ex_rw      (ex_rw),
    .ex_is_load (ex_is_load),
    .wb_dr      (wb_dr),
    .wb_rw      (wb_rw),
    .ex_br_taken(ex_br_taken),
    .if_halt    (if_halt),
    .pc_load    (pc_load),
    .stage_valid(stage_valid),
    .flush_if   (flush_if),
    .flush_id   (flush_id),
    .fwd_a_sel  (fwd_a_sel),
    .fwd_b_sel  (fwd_b_sel),
    .halt       (halt),
    .retire_cnt (retire_cnt),
    .stall_cnt  (stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb act = {pc_load, stage_valid, flush_if, flush_id, fwd_a_sel, fwd_b_sel, halt};

  function automatic snap_t mk(logic pc, logic [3:0] v, logic fi, logic fd, logic [1:0] fa,
                               logic [1:0] fb, logic h);
    snap_t s;
    s.pc_load = pc;
    s.valid   = v;
    s.fl_if   = fi;
    s.fl_id   = fd;
    s.fa      = fa;
    s.fb      = fb;
    s.halt    = h;
    return s;
  endfunction

  task automatic idle();
    id_sa = '0; id_sb = '0; id_use_a = 0; id_use_b = 0;
    ex_dr = '0; ex_rw = 0; ex_is_load = 0; wb_dr = '0; wb_rw = 0;
    ex_br_taken = 0; if_halt = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    #1;
    exp_q.push_back(mk(0, 4'b0000, 0, 0, 2'd0, 2'd0, 0));
    e = exp_q.pop_front(); total++;
    if (act !== e) begin bad++; $display("FAIL reset_state got=%h want=%h", act, e); end
    total++;
    if (retire_cnt !== 32'd0 || stall_cnt !== 16'd0) begin
      bad++; $display("FAIL reset_counters got=%0d/%0d want=0/0", retire_cnt, stall_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(mk(0, 4'b0000, 0, 0, 2'd0, 2'd0, 0));
    exp_q.push_back(mk(0, 4'b0000, 0, 0, 2'd0, 2'd0, 0));
    exp_q.push_back(mk(1, 4'b0000, 0, 0, 2'd0, 2'd0, 0));
    exp_q.push_back(mk(1, 4'b0001, 0, 0, 2'd0, 2'd0, 0));
    exp_q.push_back(mk(1, 4'b0011, 0, 0, 2'd0, 2'd0, 0));
    exp_q.push_back(mk(1, 4'b0111, 0, 0, 2'd0, 2'd0, 0));
    exp_q.push_back(mk(1, 4'b1111, 0, 0, 2'd0, 2'd0, 0));
    #1;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) tick();
      e = exp_q.pop_front(); total++;
      if (act !== e) begin bad++; $display("FAIL warmup[%0d] got=%h want=%h", i, act, e); end
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (retire_cnt !== 32'(i)) begin
        bad++; $display("FAIL retire_fill[%0d] got=%0d want=%0d", i, retire_cnt, i);
      end
      tick();
    end
  endtask

  task automatic test_forward();
    fwd_vec_t tbl [5];
    tbl[0] = '{5'd5, 5'd5, 1'b1, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1, 2'd1, 2'd0};
    tbl[1] = '{5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 2'd0, 2'd0};
    tbl[2] = '{5'd5, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 5'd5, 1'b1, 2'd2, 2'd1};
    tbl[3] = '{5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 5'd5, 1'b1, 2'd2, 2'd2};
    tbl[4] = '{5'd9, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 5'd9, 1'b0, 2'd0, 2'd0};
    for (int i = 0; i < 5; i++) begin
      id_sa = tbl[i].sa; id_sb = tbl[i].sb; id_use_a = tbl[i].ua; id_use_b = tbl[i].ub;
      ex_dr = tbl[i].exd; ex_rw = tbl[i].exrw; wb_dr = tbl[i].wbd; wb_rw = tbl[i].wbrw;
      exp_q.push_back(mk(1, 4'b1111, 0, 0, tbl[i].fa, tbl[i].fb, 0));
      #1;
      e = exp_q.pop_front(); total++;
      if (act !== e) begin bad++; $display("FAIL forward[%0d] got=%h want=%h", i, act, e); end
    end
    idle();
    tick();
  endtask

  task automatic test_load_use();
    ex_dr = 5'd3; ex_rw = 1; ex_is_load = 1; id_sb = 5'd3; id_use_b = 1;
    exp_q.push_back(mk(0, 4'b1111, 0, 0, 2'd0, 2'd1, 0));
    #1;
    e = exp_q.pop_front(); total++;
    if (act !== e) begin bad++; $display("FAIL load_use_stall got=%h want=%h", act, e); end
    tick();
    ex_rw = 0; ex_is_load = 0; wb_dr = 5'd3; wb_rw = 1;
    exp_q.push_back(mk(1, 4'b1011, 0, 0, 2'd0, 2'd2, 0));
    #1;
    e = exp_q.pop_front(); total++;
    if (act !== e) begin bad++; $display("FAIL load_use_wb got=%h want=%h", act, e); end
    total++;
    if (stall_cnt !== 16'd1) begin bad++; $display("FAIL stall_cnt got=%0d want=1", stall_cnt); end
    tick();
    idle();
    exp_q.push_back(mk(1, 4'b0111, 0, 0, 2'd0, 2'd0, 0));
    exp_q.push_back(mk(1, 4'b1111, 0, 0, 2'd0, 2'd0, 0));
    for (int i = 0; i < 2; i++) begin
      #1;
      e = exp_q.pop_front(); total++;
      if (act !== e) begin bad++; $display("FAIL load_use_drain[%0d] got=%h want=%h", i, act, e); end
      tick();
    end
  endtask

  task automatic test_branch();
    ex_br_taken = 1;
    exp_q.push_back(mk(1, 4'b1111, 1, 1, 2'd0, 2'd0, 0));
    exp_q.push_back(mk(1, 4'b1000, 1, 0, 2'd0, 2'd0, 0));
    exp_q.push_back(mk(1, 4'b0000, 0, 0, 2'd0, 2'd0, 0));
    exp_q.push_back(mk(1, 4'b0001, 0, 0, 2'd0, 2'd0, 0));
    exp_q.push_back(mk(1, 4'b0011, 0, 0, 2'd0, 2'd0, 0));
    exp_q.push_back(mk(1, 4'b0111, 0, 0, 2'd0, 2'd0, 0));
    exp_q.push_back(mk(1, 4'b1111, 0, 0, 2'd0, 2'd0, 0));
    for (int i = 0; i < 7; i++) begin
      #1;
      e = exp_q.pop_front(); total++;
      if (act !== e) begin bad++; $display("FAIL branch[%0d] got=%h want=%h", i, act, e); end
      tick();
      ex_br_taken = 0;
    end
  endtask

  task automatic test_branch_load_use();
    ex_br_taken = 1; ex_dr = 5'd3; ex_rw = 1; ex_is_load = 1; id_sb = 5'd3; id_use_b = 1;
    exp_q.push_back(mk(1, 4'b1111, 1, 1, 2'd0, 2'd1, 0));
    #1;
    e = exp_q.pop_front(); total++;
    if (act !== e) begin bad++; $display("FAIL br_load_use got=%h want=%h", act, e); end
    tick();
    idle();
    exp_q.push_back(mk(1, 4'b1000, 1, 0, 2'd0, 2'd0, 0));
    #1;
    e = exp_q.pop_front(); total++;
    if (act !== e) begin bad++; $display("FAIL br_load_use_next got=%h want=%h", act, e); end
    total++;
    if (stall_cnt !== 16'd1) begin
      bad++; $display("FAIL br_stall_cnt got=%0d want=1", stall_cnt);
    end
    repeat (5) tick();
  endtask

  task automatic test_back_to_back();
    ex_br_taken = 1;
    exp_q.push_back(mk(1, 4'b1111, 1, 1, 2'd0, 2'd0, 0));
    exp_q.push_back(mk(1, 4'b1000, 1, 1, 2'd0, 2'd0, 0));
    exp_q.push_back(mk(1, 4'b0000, 1, 0, 2'd0, 2'd0, 0));
    exp_q.push_back(mk(1, 4'b0000, 0, 0, 2'd0, 2'd0, 0));
    for (int i = 0; i < 4; i++) begin
      #1;
      e = exp_q.pop_front(); total++;
      if (act !== e) begin bad++; $display("FAIL shadow_restart[%0d] got=%h want=%h", i, act, e); end
      tick();
      ex_br_taken = (i == 0);
    end
    repeat (3) tick();
    exp_q.push_back(mk(1, 4'b1111, 0, 0, 2'd0, 2'd0, 0));
    #1;
    e = exp_q.pop_front(); total++;
    if (act !== e) begin bad++; $display("FAIL shadow_refill got=%h want=%h", act, e); end
  endtask

  task automatic test_halt();
    rst_n = 1'b0;
    #1;
    exp_q.push_back(mk(0, 4'b0000, 0, 0, 2'd0, 2'd0, 0));
    e = exp_q.pop_front(); total++;
    if (act !== e) begin bad++; $display("FAIL midop_reset got=%h want=%h", act, e); end
    total++;
    if (retire_cnt !== 32'd0 || stall_cnt !== 16'd0) begin
      bad++; $display("FAIL midop_counters got=%0d/%0d want=0/0", retire_cnt, stall_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();
    if_halt = 1;
    exp_q.push_back(mk(1, 4'b0011, 0, 0, 2'd0, 2'd0, 0));
    exp_q.push_back(mk(1, 4'b0111, 0, 0, 2'd0, 2'd0, 0));
    exp_q.push_back(mk(1, 4'b1111, 0, 0, 2'd0, 2'd0, 0));
    exp_q.push_back(mk(0, 4'b1111, 0, 0, 2'd0, 2'd0, 1));
    exp_q.push_back(mk(0, 4'b1111, 0, 0, 2'd0, 2'd0, 1));
    exp_q.push_back(mk(0, 4'b1111, 0, 0, 2'd0, 2'd0, 1));
    for (int i = 0; i < 6; i++) begin
      tick();
      e = exp_q.pop_front(); total++;
      if (act !== e) begin bad++; $display("FAIL halt_seq[%0d] got=%h want=%h", i, act, e); end
    end
    total++;
    if (retire_cnt !== 32'd1) begin bad++; $display("FAIL halt_retire got=%0d want=1", retire_cnt); end
    idle();
    rst_n = 1'b0;
    #1;
    exp_q.push_back(mk(0, 4'b0000, 0, 0, 2'd0, 2'd0, 0));
    e = exp_q.pop_front(); total++;
    if (act !== e) begin bad++; $display("FAIL halt_clear got=%h want=%h", act, e); end
    total++;
    if (retire_cnt !== 32'd0) begin bad++; $display("FAIL halt_clear_retire got=%0d want=0", retire_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b1;
    idle();
    #3;
    test_reset();
    test_forward();
    test_load_use();
    test_branch();
    test_branch_load_use();
    test_back_to_back();
    test_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
